// File: rtl/lc2k_multicycle_ctrl.sv
// Multicycle LC2K control FSM: fetch, decode, execute, memory and writeback sequencing.
// Optional performance counters are enabled with the LC2K_PERF_CNT_EN macro.
module lc2k_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       opcode,
    input  logic             alu_eq,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             CONTROL_ALUvalB,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             wb_dst,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             halted,
    output logic             bus_error
`ifdef LC2K_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
`endif
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALU_WB, S_ADDR, S_MEM_RD, S_MEM_WR,
        S_LW_WB, S_BEQ, S_BEQ_UPD, S_JALR, S_ADV, S_HALT, S_ERR
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_write;
        logic       val_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       wb_dst;
        logic       pc_write;
        logic [1:0] pc_sel;
        logic       halted;
        logic       bus_error;
    } ctl_t;

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t        state, next_state;
    logic [TW-1:0] tcnt;
    logic          eq_q;
    logic          in_mem;
    logic          timeout_hit;
    ctl_t          ctl;

    assign in_mem = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // The counter holds the number of non-ack cycles already spent, so expiry is
    // the cycle in which it reads MEM_TIMEOUT-1 and the ack is still missing.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (tcnt == TW'(MEM_TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            tcnt  <= '0;
            eq_q  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_BEQ)
                eq_q <= alu_eq;
            if (next_state != state)
                tcnt <= '0;
            else if (in_mem)
                tcnt <= tcnt + 1'b1;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        ctl        = '0;
        case (state)
            S_FETCH: begin
                ctl.mem_req  = 1'b1;
                ctl.ir_write = mem_ack;
                if (mem_ack)
                    next_state = S_DECODE;
                else if (timeout_hit)
                    next_state = S_ERR;
            end
            S_DECODE: begin
                case (opcode)
                    3'b000, 3'b001: next_state = S_EXEC;
                    3'b010, 3'b011: next_state = S_ADDR;
                    3'b100:         next_state = S_BEQ;
                    3'b101:         next_state = S_JALR;
                    3'b110:         next_state = S_HALT;
                    default:        next_state = S_ADV;
                endcase
            end
            S_EXEC: begin
                ctl.val_b  = 1'b1;
                ctl.alu_op = {1'b0, opcode[0]};
                next_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctl.reg_write = 1'b1;
                ctl.pc_write  = 1'b1;
                next_state    = S_FETCH;
            end
            S_ADDR: begin
                next_state = opcode[0] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctl.mem_req      = 1'b1;
                ctl.mem_addr_sel = 1'b1;
                if (mem_ack)
                    next_state = S_LW_WB;
                else if (timeout_hit)
                    next_state = S_ERR;
            end
            S_MEM_WR: begin
                ctl.mem_req      = 1'b1;
                ctl.mem_we       = 1'b1;
                ctl.mem_addr_sel = 1'b1;
                if (mem_ack)
                    next_state = S_ADV;
                else if (timeout_hit)
                    next_state = S_ERR;
            end
            S_LW_WB: begin
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = 2'b01;
                ctl.wb_dst    = 1'b1;
                ctl.pc_write  = 1'b1;
                next_state    = S_FETCH;
            end
            S_BEQ: begin
                ctl.val_b  = 1'b1;
                ctl.alu_op = 2'b10;
                next_state = S_BEQ_UPD;
            end
            S_BEQ_UPD: begin
                ctl.pc_write = 1'b1;
                ctl.pc_sel   = eq_q ? 2'b01 : 2'b00;
                next_state   = S_FETCH;
            end
            S_JALR: begin
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = 2'b10;
                ctl.wb_dst    = 1'b1;
                ctl.pc_write  = 1'b1;
                ctl.pc_sel    = 2'b10;
                next_state    = S_FETCH;
            end
            S_ADV: begin
                ctl.pc_write = 1'b1;
                next_state   = S_FETCH;
            end
            S_HALT:  ctl.halted    = 1'b1;
            S_ERR:   ctl.bus_error = 1'b1;
            default: next_state    = S_FETCH;
        endcase
        // Reset forces every output low, so no request or write escapes mid-reset.
        if (reset)
            ctl = '0;
    end

    assign mem_req         = ctl.mem_req;
    assign mem_we          = ctl.mem_we;
    assign mem_addr_sel    = ctl.mem_addr_sel;
    assign ir_write        = ctl.ir_write;
    assign CONTROL_ALUvalB = ctl.val_b;
    assign alu_op          = ctl.alu_op;
    assign reg_write       = ctl.reg_write;
    assign wb_sel          = ctl.wb_sel;
    assign wb_dst          = ctl.wb_dst;
    assign pc_write        = ctl.pc_write;
    assign pc_sel          = ctl.pc_sel;
    assign halted          = ctl.halted;
    assign bus_error       = ctl.bus_error;

`ifdef LC2K_PERF_CNT_EN
    logic retire;
    assign retire = (next_state != state) &&
                    ((next_state == S_FETCH) || (next_state == S_HALT));

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            if ((state != S_HALT) && (state != S_ERR) && (cycle_cnt != '1))
                cycle_cnt <= cycle_cnt + 1'b1;
            if (retire && (instret != '1))
                instret <= instret + 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^CNT_W;
`endif

endmodule

// File: tb/tb_lc2k_multicycle_ctrl.sv
// Directed bench for lc2k_multicycle_ctrl; expected control vectors are hand-built per state.
// Perf-counter checks are compiled only when LC2K_PERF_CNT_EN is defined.
module tb_lc2k_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  opcode;
    logic        alu_eq;
    logic        mem_ack;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, val_b;
    logic [1:0]  alu_op, wb_sel, pc_sel;
    logic        reg_write, wb_dst, pc_write, halted, bus_error;
`ifdef LC2K_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lc2k_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .opcode          (opcode),
        .alu_eq          (alu_eq),
        .mem_ack         (mem_ack),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr_sel    (mem_addr_sel),
        .ir_write        (ir_write),
        .CONTROL_ALUvalB (val_b),
        .alu_op          (alu_op),
        .reg_write       (reg_write),
        .wb_sel          (wb_sel),
        .wb_dst          (wb_dst),
        .pc_write        (pc_write),
        .pc_sel          (pc_sel),
        .halted          (halted),
        .bus_error       (bus_error)
`ifdef LC2K_PERF_CNT_EN
        ,
        .cycle_cnt       (cycle_cnt),
        .instret         (instret)
`endif
    );

    logic [15:0] outs;
    assign outs = {mem_req, mem_we, mem_addr_sel, ir_write, val_b, alu_op,
                   reg_write, wb_sel, wb_dst, pc_write, pc_sel, halted, bus_error};

    function automatic logic [15:0] mk(input logic req, we, asel, irw, vb,
                                       input logic [1:0] aop, input logic rw,
                                       input logic [1:0] wbs, input logic wbd, pcw,
                                       input logic [1:0] pcs, input logic h, be);
        return {req, we, asel, irw, vb, aop, rw, wbs, wbd, pcw, pcs, h, be};
    endfunction

    localparam logic [15:0] ZERO     = 16'h0000;
    localparam logic [15:0] F_IDLE   = mk(1,0,0,0,0,2'b00,0,2'b00,0,0,2'b00,0,0);
    localparam logic [15:0] F_ACK    = mk(1,0,0,1,0,2'b00,0,2'b00,0,0,2'b00,0,0);
    localparam logic [15:0] DEC      = ZERO;
    localparam logic [15:0] ADDR     = ZERO;
    localparam logic [15:0] EXEC_ADD = mk(0,0,0,0,1,2'b00,0,2'b00,0,0,2'b00,0,0);
    localparam logic [15:0] EXEC_NOR = mk(0,0,0,0,1,2'b01,0,2'b00,0,0,2'b00,0,0);
    localparam logic [15:0] ALU_WB   = mk(0,0,0,0,0,2'b00,1,2'b00,0,1,2'b00,0,0);
    localparam logic [15:0] MEM_RD   = mk(1,0,1,0,0,2'b00,0,2'b00,0,0,2'b00,0,0);
    localparam logic [15:0] MEM_WR   = mk(1,1,1,0,0,2'b00,0,2'b00,0,0,2'b00,0,0);
    localparam logic [15:0] LW_WB    = mk(0,0,0,0,0,2'b00,1,2'b01,1,1,2'b00,0,0);
    localparam logic [15:0] BEQ      = mk(0,0,0,0,1,2'b10,0,2'b00,0,0,2'b00,0,0);
    localparam logic [15:0] BEQ_TK   = mk(0,0,0,0,0,2'b00,0,2'b00,0,1,2'b01,0,0);
    localparam logic [15:0] BEQ_NT   = mk(0,0,0,0,0,2'b00,0,2'b00,0,1,2'b00,0,0);
    localparam logic [15:0] JALR     = mk(0,0,0,0,0,2'b00,1,2'b10,1,1,2'b10,0,0);
    localparam logic [15:0] ADV      = mk(0,0,0,0,0,2'b00,0,2'b00,0,1,2'b00,0,0);
    localparam logic [15:0] HALTV    = mk(0,0,0,0,0,2'b00,0,2'b00,0,0,2'b00,1,0);
    localparam logic [15:0] ERRV     = mk(0,0,0,0,0,2'b00,0,2'b00,0,0,2'b00,0,1);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drive mem_ack for the current cycle, check outputs, then advance one clock.
    task automatic step(input string tag, input logic ack, input logic [15:0] exp);
        mem_ack = ack;
        #1;
        check(tag, {16'h0, outs}, {16'h0, exp});
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset   = 1'b1;
        mem_ack = 1'b1;
        #1;
        check(tag, {16'h0, outs}, {16'h0, ZERO});
        @(posedge clk);
        #1;
        reset   = 1'b0;
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; opcode = 3'b000; alu_eq = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        do_reset("reset_outs");

        // add, 1-cycle ack; an ack in DECODE is ignored
        opcode = 3'b000;
        step("add_fetch", 1, F_ACK);
        step("add_dec",   1, DEC);
        step("add_exec",  0, EXEC_ADD);
        step("add_wb",    0, ALU_WB);

        // nor, fetch ack delayed to the 4th cycle (ack wins at expiry)
        opcode = 3'b001;
        for (int i = 0; i < 3; i++) step("nor_fetch_wait", 0, F_IDLE);
        step("nor_fetch_ack", 1, F_ACK);
        step("nor_dec",  0, DEC);
        step("nor_exec", 0, EXEC_NOR);
        step("nor_wb",   0, ALU_WB);

        // lw, memory ack delay 3
        opcode = 3'b010;
        step("lw_fetch", 1, F_ACK);
        step("lw_dec",   0, DEC);
        step("lw_addr",  1, ADDR);
        for (int i = 0; i < 3; i++) step("lw_mem_wait", 0, MEM_RD);
        step("lw_mem_ack", 1, MEM_RD);
        step("lw_wb",    0, LW_WB);

        // beq taken: alu_eq captured in BEQ, dropped afterwards
        opcode = 3'b100;
        step("beq1_fetch", 1, F_ACK);
        step("beq1_dec",   0, DEC);
        alu_eq = 1'b1;
        step("beq1_cmp",   0, BEQ);
        alu_eq = 1'b0;
        step("beq1_upd",   0, BEQ_TK);

        // beq not taken: alu_eq raised only after BEQ must not matter
        step("beq0_fetch", 1, F_ACK);
        step("beq0_dec",   0, DEC);
        step("beq0_cmp",   0, BEQ);
        alu_eq = 1'b1;
        step("beq0_upd",   0, BEQ_NT);
        alu_eq = 1'b0;

        // jalr and noop
        opcode = 3'b101;
        step("jalr_fetch", 1, F_ACK);
        step("jalr_dec",   0, DEC);
        step("jalr_exec",  0, JALR);
        opcode = 3'b111;
        step("noop_fetch", 1, F_ACK);
        step("noop_dec",   0, DEC);
        step("noop_adv",   0, ADV);

        // sw with ack on 4th MEM_WR cycle -> ADV, no error
        opcode = 3'b011;
        step("sw_fetch", 1, F_ACK);
        step("sw_dec",   0, DEC);
        step("sw_addr",  0, ADDR);
        for (int i = 0; i < 3; i++) step("sw_mem_wait", 0, MEM_WR);
        step("sw_mem_ack", 1, MEM_WR);
        step("sw_adv",   0, ADV);

        // sw, ack never arrives: error after 4 MEM_WR cycles, sticky
        step("swto_fetch", 1, F_ACK);
        step("swto_dec",   0, DEC);
        step("swto_addr",  0, ADDR);
        for (int i = 0; i < 4; i++) step("swto_mem_wait", 0, MEM_WR);
        for (int i = 0; i < 5; i++) step("swto_err", 1'(i % 2), ERRV);
        do_reset("swto_reset");
        step("swto_refetch", 0, F_IDLE);

        // reset during a write request: nothing escapes, restart in FETCH
        step("rstmid_fetch", 1, F_ACK);
        step("rstmid_dec",   0, DEC);
        step("rstmid_addr",  0, ADDR);
        step("rstmid_mem",   0, MEM_WR);
        do_reset("rstmid_reset");
        step("rstmid_refetch", 0, F_IDLE);

        // halt: absorbing, no mem_req for 20 cycles, cleared by 1-cycle reset
        opcode = 3'b110;
        step("halt_fetch", 1, F_ACK);
        step("halt_dec",   0, DEC);
        for (int i = 0; i < 20; i++) step("halt_hold", 1'(i % 2), HALTV);
        do_reset("halt_reset");
        step("halt_refetch", 0, F_IDLE);

`ifdef LC2K_PERF_CNT_EN
        // add (4) + noop (3) + halt fetch/decode (2) = 9 counted cycles; 3 retirements
        do_reset("perf_reset");
        check("perf_cnt_clear", cycle_cnt, 32'd0);
        opcode = 3'b000;
        step("perf_add_f", 1, F_ACK);
        step("perf_add_d", 0, DEC);
        step("perf_add_e", 0, EXEC_ADD);
        step("perf_add_w", 0, ALU_WB);
        opcode = 3'b111;
        step("perf_noop_f", 1, F_ACK);
        step("perf_noop_d", 0, DEC);
        step("perf_noop_a", 0, ADV);
        opcode = 3'b110;
        step("perf_halt_f", 1, F_ACK);
        step("perf_halt_d", 0, DEC);
        check("perf_instret", instret, 32'd3);
        check("perf_cycles", cycle_cnt, 32'd9);
        for (int i = 0; i < 5; i++) step("perf_halt_hold", 0, HALTV);
        check("perf_instret_frozen", instret, 32'd3);
        check("perf_cycles_frozen", cycle_cnt, 32'd9);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
